onchip_ram_clr: RTL and testbench
=================================

// Module: onchip_ram_clr
// PURPOSE
//  Parametrised single-port on-chip RAM with an Avalon-MM slave and pipelined reads.
//  Successor to the fixed 4096x32 system RAM: width, depth and read latency are configurable.
//  Adds a hardware clear engine that fills every word with CLEAR_VALUE after reset or on request.
//  Sits on the CPU data master in watchdog/ultrasonic CPU subsystems as scratch/stack memory.
// PARAMETERS
//  DATA_W          32    data width in bits; must be a multiple of 8
//  ADDR_W          12    word address width; depth = 2**ADDR_W words
//  OUT_REG         0     0: read latency 1 cycle; 1: extra output register, latency 2
//  CLEAR_ON_RESET  1     1: run the clear engine automatically when reset_n releases
//  CLEAR_VALUE     0     DATA_W-bit fill word written by the clear engine
// PORTS
//  clk            in   1          single clock; all logic is on the rising edge
//  reset_n        in   1          synchronous, active-low reset
//  address        in   ADDR_W     word address
//  byteenable     in   DATA_W/8   byte lanes for writes; ignored on reads
//  chipselect     in   1          slave select
//  read           in   1          read request
//  write          in   1          write request
//  writedata      in   DATA_W     write data
//  readdata       out  DATA_W     read data; valid only while readdatavalid=1
//  readdatavalid  out  1          one-cycle pulse per accepted read
//  waitrequest    out  1          1 = request not accepted this cycle
//  clken          in   1          global clock enable; 0 freezes RAM and pipeline
//  reset_req      in   1          1 = gate the RAM clock enable (clocken = clken & ~reset_req)
//  clear_req      in   1          level/pulse; starts a clear while IDLE
//  clear_busy     out  1          1 while the clear engine runs
// BEHAVIOUR
//  - Reset (reset_n=0 at a clk edge): readdatavalid=0, pipeline valid bits=0,
//    readdata=0 when OUT_REG=1.
//    State is CLEAR with clr_addr=0 if CLEAR_ON_RESET=1, otherwise IDLE.
//    clear_busy and waitrequest follow from the state.
//  - clocken = clken & ~reset_req. While clocken=0:
//    * no state, address or pipeline register advances;
//    * the RAM is not written;
//    * waitrequest=1.
//  - waitrequest = clear_busy | ~clocken (combinational).
//  - Accept = chipselect & (read|write) & ~waitrequest.
//  - State IDLE:
//    * accepted write updates only the byte lanes whose byteenable bit is 1;
//    * accepted read issues a RAM read;
//    * read=write=1 together: the write is performed, no read is issued, no readdatavalid.
//  - Read pipeline: readdatavalid asserts exactly 1+OUT_REG clocken-cycles after the accept,
//    for 1 cycle, carrying the RAM word.
//    Back-to-back reads are accepted every cycle (throughput 1/cycle).
//  - IDLE -> CLEAR: when clear_req=1 and clocken=1; clr_addr<=0.
//  - State CLEAR:
//    * each clocken cycle writes CLEAR_VALUE (all lanes) to clr_addr;
//    * clr_addr increments by 1; at clr_addr = 2**ADDR_W-1 the word is written, then -> IDLE;
//    * a full clear takes exactly 2**ADDR_W clocken cycles;
//    * clear_busy = 1 and all bus requests are stalled;
//    * clear_req during CLEAR is ignored (no restart, no queue).
//  - Reads in flight when a clear starts still complete with their pre-clear data and latency.
//  - Reset mid-clear:
//    * CLEAR_ON_RESET=1: restart from address 0;
//    * CLEAR_ON_RESET=0: go to IDLE with memory partially cleared (content unspecified).
//  - clr_addr is ADDR_W wide; no wrap beyond the last word; memory contents are not reset by reset_n.
//  - readdata when readdatavalid=0: 0 if OUT_REG=1, unspecified if OUT_REG=0.
// TESTING
//  - Reset release, CLEAR_ON_RESET=1, ADDR_W=4:
//    clear_busy=1 for exactly 16 cycles, waitrequest=1 throughout, then every word reads 0.
//  - Write 0xA5A5A5A5 to addr 3 (byteenable=4'hF), then write 0x11223344 with byteenable=4'b0101:
//    read of addr 3 returns 0xA522A544.
//  - Reads to addr 0,1,2 on consecutive cycles, OUT_REG=1:
//    readdatavalid high on cycles +2,+3,+4 with the matching data; with OUT_REG=0 on +1,+2,+3.
//  - clken=0 for 3 cycles during a read:
//    readdatavalid is delayed by exactly 3 cycles, data unchanged; waitrequest=1 while clken=0.
//  - clear_req pulse in IDLE after writing 0xDEADBEEF to addr 7:
//    * 16 busy cycles, then addr 7 reads CLEAR_VALUE;
//    * a second clear_req mid-clear does not extend busy.
//  - reset_n=0 for 1 cycle at clr_addr=9 (CLEAR_ON_RESET=1):
//    clear restarts at 0 and busy lasts 16 cycles from the release.

Source files
------------

// File: rtl/onchip_ram_clr.sv
// Single-port on-chip RAM with Avalon-MM slave, pipelined reads and a
// hardware clear engine that fills every word with CLEAR_VALUE.
module onchip_ram_clr #(
   parameter int unsigned         DATA_W         = 32,
   parameter int unsigned         ADDR_W         = 12,
   parameter int unsigned         OUT_REG        = 0,
   parameter int unsigned         CLEAR_ON_RESET = 1,
   parameter logic [DATA_W-1:0]   CLEAR_VALUE    = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W/8-1:0]   byteenable,
   input  logic                  chipselect,
   input  logic                  read,
   input  logic                  write,
   input  logic [DATA_W-1:0]     writedata,
   output logic [DATA_W-1:0]     readdata,
   output logic                  readdatavalid,
   output logic                  waitrequest,
   input  logic                  clken,
   input  logic                  reset_req,
   input  logic                  clear_req,
   output logic                  clear_busy
);

   localparam int unsigned LANES = DATA_W / 8;
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   clr_addr;
   logic                clocken;
   logic                accept;
   logic                wr_acc;
   logic                rd_acc;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   ram_q;
   logic                ram_vld;

   always_comb begin
      clocken     = clken & ~reset_req;
      clear_busy  = (state == CLEAR);
      waitrequest = clear_busy | ~clocken;
      accept      = chipselect & (read | write) & ~waitrequest;
      wr_acc      = accept & write;
      rd_acc      = accept & read & ~write;
   end

   // RAM array: contents survive reset; accepts only happen in IDLE
   always_ff @(posedge clk) begin
      if (clocken && reset_n) begin
         if (state == CLEAR) begin
            mem[clr_addr] <= CLEAR_VALUE;
         end else if (wr_acc) begin
            for (int unsigned i = 0; i < LANES; i++) begin
               if (byteenable[i]) begin
                  mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
               end
            end
         end
         if (rd_acc) begin
            ram_q <= mem[address];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         clr_addr <= '0;
         ram_vld  <= 1'b0;
      end else if (clocken) begin
         ram_vld <= rd_acc;
         case (state)
            IDLE: begin
               if (clear_req) begin
                  state    <= CLEAR;
                  clr_addr <= '0;
               end
            end
            CLEAR: begin
               if (clr_addr == '1) begin
                  state <= IDLE;
               end else begin
                  clr_addr <= clr_addr + ADDR_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Valid is qualified by clocken so a frozen pipeline never repeats a beat
   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] data_q;
      logic              vld_q;

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            data_q <= '0;
            vld_q  <= 1'b0;
         end else if (clocken) begin
            vld_q  <= ram_vld;
            data_q <= ram_vld ? ram_q : '0;
         end
      end

      always_comb begin
         readdatavalid = vld_q & clocken;
         readdata      = readdatavalid ? data_q : '0;
      end
   end else begin : g_no_reg
      always_comb begin
         readdatavalid = ram_vld & clocken;
         readdata      = ram_q;
      end
   end

endmodule

// File: tb/tb_onchip_ram_clr.sv
// Bench for onchip_ram_clr: two instances (OUT_REG=1 and OUT_REG=0) share the
// same stimulus and are checked every cycle against a queue-based memory model.
module tb_onchip_ram_clr;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, chipselect, read, write, clken, reset_req, clear_req;
   logic [3:0]  address;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic [31:0] rd0, rd1;
   logic        rdv0, rdv1, wr0, wr1, busy0, busy1;

   onchip_ram_clr #(
      .DATA_W(32), .ADDR_W(4), .OUT_REG(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)
   ) u_dut1 (
      .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .readdata(rd1), .readdatavalid(rdv1), .waitrequest(wr1), .clken(clken),
      .reset_req(reset_req), .clear_req(clear_req), .clear_busy(busy1)
   );

   onchip_ram_clr #(
      .DATA_W(32), .ADDR_W(4), .OUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)
   ) u_dut0 (
      .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .readdata(rd0), .readdatavalid(rdv0), .waitrequest(wr0), .clken(clken),
      .reset_req(reset_req), .clear_req(clear_req), .clear_busy(busy0)
   );

   int n_cmp = 0;
   int n_err = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Behavioural model: memory image, remaining clear words, in-flight reads with age
   typedef struct {
      logic [31:0] data;
      int          age;
   } rd_t;

   logic [31:0] mmem [DEPTH];
   int          busy_left = 0;
   rd_t         q0[$];
   rd_t         q1[$];
   bit          chk_en = 1'b0;

   always @(posedge clk) begin : model
      bit ce;
      ce = clken && !reset_req;
      if (reset_n !== 1'b1) begin
         busy_left = DEPTH;
         q0.delete();
         q1.delete();
      end else if (ce) begin
         if (q0.size() > 0 && q0[0].age == 0) void'(q0.pop_front());
         foreach (q0[i]) q0[i].age = q0[i].age + 1;
         if (q1.size() > 0 && q1[0].age == 1) void'(q1.pop_front());
         foreach (q1[i]) q1[i].age = q1[i].age + 1;
         if (busy_left > 0) begin
            mmem[DEPTH - busy_left] = 32'h0;
            busy_left--;
         end else begin
            if (chipselect && write) begin
               for (int b = 0; b < 4; b++)
                  if (byteenable[b]) mmem[address][8*b +: 8] = writedata[8*b +: 8];
            end else if (chipselect && read) begin
               q0.push_back('{data: mmem[address], age: 0});
               q1.push_back('{data: mmem[address], age: 0});
            end
            if (clear_req) busy_left = DEPTH;
         end
      end
   end

   always @(negedge clk) begin : compare
      bit ce, e0, e1;
      if (chk_en) begin
         ce = clken && !reset_req;
         e0 = ce && q0.size() > 0 && q0[0].age == 0;
         e1 = ce && q1.size() > 0 && q1[0].age == 1;
         check("busy0", busy0, busy_left > 0);
         check("busy1", busy1, busy_left > 0);
         check("wreq0", wr0, (busy_left > 0) || !ce);
         check("wreq1", wr1, (busy_left > 0) || !ce);
         check("rdv0", rdv0, e0);
         check("rdv1", rdv1, e1);
         if (e0) check("rdata0", rd0, q0[0].data);
         if (e1) check("rdata1", rd1, q1[0].data);
         else    check("rdata1_idle", rd1, 32'h0);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus;
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; read = 1'b0;
      address = a; byteenable = be; writedata = d;
      tick;
      idle_bus;
   endtask

   task automatic do_read(input logic [3:0] a, output logic [31:0] d0, output logic [31:0] d1,
                          output int l0, output int l1);
      chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
      tick;
      idle_bus;
      l0 = -1; l1 = -1; d0 = '0; d1 = '0;
      for (int k = 1; k <= 8; k++) begin
         #1;
         if (rdv0 && l0 < 0) begin l0 = k; d0 = rd0; end
         if (rdv1 && l1 < 0) begin l1 = k; d1 = rd1; end
         tick;
      end
   endtask

   task automatic count_busy(input int pulse_at, output int n);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         clear_req = (k == pulse_at);
         #1;
         if (!busy1) break;
         n++;
         tick;
      end
      clear_req = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [31:0] d0, d1;
      logic [31:0] b2b_exp [3];
      int          l0, l1, n;

      reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0; clear_req = 1'b0;
      idle_bus;
      address = '0; byteenable = '0; writedata = '0;
      tick;
      chk_en = 1'b1;
      tick;

      // Reset release starts a full clear
      reset_n = 1'b1;
      count_busy(-1, n);
      check("busy_after_reset", n, 16);

      for (int a = 0; a < DEPTH; a++) begin
         do_read(4'(a), d0, d1, l0, l1);
         check("cleared_rd0", d0, 32'h0);
         check("cleared_rd1", d1, 32'h0);
         if (a == 0) begin
            check("latency0", l0, 1);
            check("latency1", l1, 2);
         end
      end

      // Byte-lane merge
      do_write(4'd3, 4'hF, 32'hA5A5_A5A5);
      do_write(4'd3, 4'b0101, 32'h1122_3344);
      do_read(4'd3, d0, d1, l0, l1);
      check("merge_rd0", d0, 32'hA522_A544);
      check("merge_rd1", d1, 32'hA522_A544);

      // Back-to-back reads at full throughput
      b2b_exp[0] = 32'h1111_0000;
      b2b_exp[1] = 32'h2222_0001;
      b2b_exp[2] = 32'h3333_0002;
      for (int i = 0; i < 3; i++) do_write(4'(i), 4'hF, b2b_exp[i]);
      for (int k = 0; k <= 6; k++) begin
         if (k < 3) begin chipselect = 1'b1; read = 1'b1; address = 4'(k); end
         else idle_bus;
         #1;
         if (k >= 1) begin
            check("b2b_v1", rdv1, k >= 2 && k <= 4);
            check("b2b_v0", rdv0, k >= 1 && k <= 3);
            if (k >= 2 && k <= 4) check("b2b_d1", rd1, b2b_exp[k-2]);
            if (k <= 3)           check("b2b_d0", rd0, b2b_exp[k-1]);
         end
         tick;
      end

      // Three-cycle clock-enable stall on an in-flight read
      chipselect = 1'b1; read = 1'b1; address = 4'd3;
      tick;
      idle_bus;
      for (int k = 1; k <= 7; k++) begin
         clken = !(k <= 3);
         #1;
         check("stall_wreq", wr1, k <= 3);
         check("stall_v0", rdv0, k == 4);
         check("stall_v1", rdv1, k == 5);
         if (k == 4) check("stall_d0", rd0, 32'hA522_A544);
         if (k == 5) check("stall_d1", rd1, 32'hA522_A544);
         tick;
      end
      clken = 1'b1;

      // Requested clear; a second request mid-clear must not extend it
      do_write(4'd7, 4'hF, 32'hDEAD_BEEF);
      clear_req = 1'b1;
      tick;
      clear_req = 1'b0;
      count_busy(5, n);
      check("busy_req_clear", n, 16);
      do_read(4'd7, d0, d1, l0, l1);
      check("clr7_rd0", d0, 32'h0);
      check("clr7_rd1", d1, 32'h0);

      // Reset while clearing word 9 restarts the clear
      do_write(4'd12, 4'hF, 32'hCAFE_F00D);
      clear_req = 1'b1;
      tick;
      clear_req = 1'b0;
      repeat (9) tick;
      reset_n = 1'b0;
      tick;
      reset_n = 1'b1;
      count_busy(-1, n);
      check("busy_restart", n, 16);
      do_read(4'd12, d0, d1, l0, l1);
      check("restart_rd1", d1, 32'h0);

      // Randomised traffic against the model
      for (int i = 0; i < 800; i++) begin
         reset_n    = ($urandom_range(0, 299) != 0);
         clken      = ($urandom_range(0, 9) != 0);
         reset_req  = ($urandom_range(0, 19) == 0);
         clear_req  = ($urandom_range(0, 79) == 0);
         chipselect = ($urandom_range(0, 3) != 0);
         read       = ($urandom_range(0, 1) != 0);
         write      = ($urandom_range(0, 2) == 0);
         address    = 4'($urandom);
         byteenable = 4'($urandom);
         writedata  = $urandom;
         tick;
      end

      reset_n = 1'b1; clken = 1'b1; reset_req = 1'b0; clear_req = 1'b0;
      idle_bus;
      repeat (24) tick;
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
